vga_scanner: RTL and testbench



---
 rtl/vga_scanner_if.sv | 10 +
 rtl/vga_scanner.sv | 92 +++++++++
 tb/tb_vga_scanner.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vga_scanner_if.sv
// rtl/vga_scanner_if.sv - pixel address / colour bus between scanner and sprite compositor
interface vga_scanner_if;
    logic [19:0] addr;
    logic [2:0]  ired;
    logic [2:0]  igreen;
    logic [2:0]  iblue;

    modport master (output addr, input ired, igreen, iblue);
    modport slave  (input addr, output ired, igreen, iblue);
endinterface

// File: rtl/vga_scanner.sv
// rtl/vga_scanner.sv - VGA raster timing generator and pixel reader
module vga_scanner #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic          clk,
    input  logic          rst,
    vga_scanner_if.master pix,
    output logic [2:0]    ored,
    output logic [2:0]    ogreen,
    output logic [2:0]    oblue,
    output logic          hs,
    output logic          vs,
    output logic          vblank,
    output logic          frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    // Keep the divider at least one bit wide so CLK_DIV=1 still elaborates.
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic [9:0]       hcount;
    logic [9:0]       vcount;
    logic             tick;
    logic             h_last;
    logic             v_last;
    logic             vis;
    logic             hs_zone;
    logic             vs_zone;

    always_comb begin
        tick    = (div == DIV_W'(CLK_DIV - 1));
        h_last  = (hcount == 10'(H_TOTAL - 1));
        v_last  = (vcount == 10'(V_TOTAL - 1));
        vis     = (hcount < 10'(H_VISIBLE)) && (vcount < 10'(V_VISIBLE));
        hs_zone = (hcount >= 10'(H_VISIBLE + H_FRONT)) &&
                  (hcount <  10'(H_VISIBLE + H_FRONT + H_SYNC));
        vs_zone = (vcount >= 10'(V_VISIBLE + V_FRONT)) &&
                  (vcount <  10'(V_VISIBLE + V_FRONT + V_SYNC));
    end

    assign pix.addr = vis ? {1'b0, hcount, vcount[8:0]} : 20'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            div    <= '0;
            hcount <= '0;
            vcount <= '0;
        end else if (tick) begin
            div <= '0;
            if (h_last) begin
                hcount <= '0;
                vcount <= v_last ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 10'd1;
            end
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Colour and sync share one register stage so they stay aligned at one pixel of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            ored        <= 3'd0;
            ogreen      <= 3'd0;
            oblue       <= 3'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && h_last && v_last;
            if (tick) begin
                ored   <= vis ? pix.ired   : 3'd0;
                ogreen <= vis ? pix.igreen : 3'd0;
                oblue  <= vis ? pix.iblue  : 3'd0;
                hs     <= !hs_zone;
                vs     <= !vs_zone;
                vblank <= (vcount >= 10'(V_VISIBLE));
            end
        end
    end
endmodule

// File: tb/tb_vga_scanner.sv
// tb/tb_vga_scanner.sv - scoreboard bench for vga_scanner at CLK_DIV=2 and CLK_DIV=1
module tb_vga_scanner;
    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int RUN = 2 * HT * VT * 2 + 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rand_en = 1'b1;
    logic [8:0] rnd = 9'd0;
    logic [19:0] addr_mon0;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int CD = (g == 0) ? 2 : 1;
        localparam string PFX = (g == 0) ? "cd2" : "cd1";

        vga_scanner_if bus ();
        logic [2:0] ored, ogreen, oblue;
        logic       hs, vs, vblank, frame_start;

        assign bus.ired   = rand_en ? rnd[2:0] : bus.addr[11:9];
        assign bus.igreen = rand_en ? rnd[5:3] : bus.addr[2:0];
        assign bus.iblue  = rand_en ? rnd[8:6] : 3'b111;

        vga_scanner #(
            .CLK_DIV(CD),
            .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
            .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .pix(bus),
            .ored(ored),
            .ogreen(ogreen),
            .oblue(oblue),
            .hs(hs),
            .vs(vs),
            .vblank(vblank),
            .frame_start(frame_start)
        );

        if (g == 0) begin : g_mon
            assign addr_mon0 = bus.addr;
        end

        int          m_div = 0;
        logic [9:0]  mh = '0, mv = '0;
        logic [11:0] sb_q[$];
        logic [11:0] cur = {9'd0, 3'b110};
        logic [11:0] item;
        logic        fs_e, ticked, mvis;
        logic [19:0] addr_e;
        longint      cyc = 0, last_fs = 0, last_hfall = 0, last_vfall = 0;
        logic        hfall_ok = 1'b0, vfall_ok = 1'b0, hs_prev = 1'b1, vs_prev = 1'b1;

        always @(posedge clk) begin
            cyc++;
            fs_e   = 1'b0;
            ticked = 1'b0;
            if (rst) begin
                m_div = 0; mh = '0; mv = '0;
                sb_q.delete();
                cur = {9'd0, 1'b1, 1'b1, 1'b0};
                last_fs = cyc;
                hfall_ok = 1'b0; vfall_ok = 1'b0;
                hs_prev = 1'b1; vs_prev = 1'b1;
            end else if (m_div == CD - 1) begin
                ticked = 1'b1;
                mvis = (mh < HV) && (mv < VV);
                item[11:3] = mvis ? {mh[2:0], mv[2:0], 3'd7} : 9'd0;
                item[2] = !((mh >= HV + HF) && (mh < HV + HF + HS));
                item[1] = !((mv >= VV + VF) && (mv < VV + VF + VS));
                item[0] = (mv >= VV);
                sb_q.push_back(item);
                fs_e = (mh == HT - 1) && (mv == VT - 1);
                m_div = 0;
                if (mh == HT - 1) begin
                    mh = '0;
                    mv = (mv == VT - 1) ? 10'd0 : mv + 10'd1;
                end else begin
                    mh = mh + 10'd1;
                end
            end else begin
                m_div++;
            end
            addr_e = ((mh < HV) && (mv < VV)) ? {1'b0, mh, mv[8:0]} : 20'd0;
            #1;
            if (ticked) cur = sb_q.pop_front();
            check_eq({PFX, " colour"}, 32'({ored, ogreen, oblue}), 32'(cur[11:3]));
            check_eq({PFX, " hs"}, 32'(hs), 32'(cur[2]));
            check_eq({PFX, " vs"}, 32'(vs), 32'(cur[1]));
            check_eq({PFX, " vblank"}, 32'(vblank), 32'(cur[0]));
            check_eq({PFX, " frame_start"}, 32'(frame_start), 32'(fs_e));
            check_eq({PFX, " addr"}, 32'(bus.addr), 32'(addr_e));
            if (!rst) begin
                if (frame_start) begin
                    check_eq({PFX, " frame_period"}, 32'(cyc - last_fs), 32'(HT * VT * CD));
                    last_fs = cyc;
                end
                if (hs_prev && !hs) begin
                    if (hfall_ok) check_eq({PFX, " line_period"}, 32'(cyc - last_hfall), 32'(HT * CD));
                    last_hfall = cyc;
                    hfall_ok = 1'b1;
                end
                if (!hs_prev && hs && hfall_ok)
                    check_eq({PFX, " hs_width"}, 32'(cyc - last_hfall), 32'(HS * CD));
                if (vs_prev && !vs) begin
                    last_vfall = cyc;
                    vfall_ok = 1'b1;
                end
                if (!vs_prev && vs && vfall_ok)
                    check_eq({PFX, " vs_width"}, 32'(cyc - last_vfall), 32'(VS * HT * CD));
                hs_prev = hs;
                vs_prev = vs;
            end
        end
    end

    initial begin
        logic found;
        rst = 1'b1;
        rand_en = 1'b1;
        repeat (5) begin
            @(negedge clk);
            rnd = 9'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        rand_en = 1'b0;
        repeat (RUN) @(negedge clk);

        found = 1'b0;
        for (int i = 0; i < 2 * HT * VT * 2 && !found; i++) begin
            @(negedge clk);
            if (addr_mon0 == {1'b0, 10'd10, 9'd5}) found = 1'b1;
        end
        check_eq("mid_reset_wait", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (RUN) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
